rtype_exec_stage: RTL and testbench
===================================

RTYPE_EXEC_STAGE -- requirements
Module: rtype_exec_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream decode has an R-type op on the in_* lines.
REQ-005 in_ready  output  1  the stage can accept an op this cycle.
REQ-006 in_rs1  input  32  source operand 1 value.
REQ-007 in_rs2  input  32  source operand 2 value; bits [4:0] are the shift amount.
REQ-008 in_funct3  input  3  RV32I funct3.
REQ-009 in_funct7  input  7  RV32I funct7.
REQ-010 in_rd  input  5  destination register index.
REQ-011 out_valid  output  1  a result is presented to writeback.
REQ-012 out_ready  input  1  writeback consumes the result this cycle.
REQ-013 out_result  output  32  computed value.
REQ-014 out_rd  output  5  destination index, passed through.
REQ-015 out_illegal  output  1  the funct3/funct7 combination is not a legal RV32I R-type op.

Function
REQ-016 An input transfer SHALL occur on any edge where in_valid && in_ready; an output transfer SHALL occur on any edge where out_valid && out_ready.
REQ-017 The op decode SHALL be: 000/0000000 ADD, 000/0100000 SUB, 001/0000000 SLL, 010/0000000 SLT, 011/0000000 SLTU, 100/0000000 XOR, 101/0000000 SRL (logical, zero fill), 101/0100000 SRA (sign fill), 110/0000000 OR, 111/0000000 AND.
REQ-018 Any other funct3/funct7 pair SHALL produce out_result = 0 and out_illegal = 1; legal ops SHALL produce out_illegal = 0.
REQ-019 Arithmetic SHALL be modulo 2^32 with no overflow flag; SLT SHALL use a signed compare, SLTU an unsigned compare, each yielding 0 or 1.
REQ-020 Shifts SHALL use in_rs2[4:0] only; in_rs2[31:5] SHALL be ignored; a shift amount of 0 SHALL return in_rs1 unchanged.
REQ-021 If in_rd = 0, out_result SHALL be 0 regardless of op; out_illegal is still reported.
REQ-022 The result SHALL be computed combinationally from the in_* lines and captured at the input transfer edge. The latency SHALL be one cycle: out_valid is high in the cycle after acceptance.
REQ-023 Buffering SHALL be a 2-entry skid buffer: an output register (OUT) plus a skid register (SKID); out_* SHALL always be driven from OUT.
REQ-024 The occupancy states SHALL be EMPTY (0 entries), ONE (OUT valid) and TWO (OUT and SKID valid).
REQ-025 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO; in_ready SHALL be a registered signal with no combinational path from out_ready.
REQ-026 Transitions:
- EMPTY + accept -> ONE.
- ONE + accept + no drain -> TWO; the new op goes to SKID.
- ONE + accept + drain -> ONE; OUT is replaced.
- ONE + drain only -> EMPTY.
- TWO + drain -> ONE; SKID moves to OUT.
- All other cases hold state.
REQ-027 While out_valid = 1 and out_ready = 0, out_result, out_rd and out_illegal SHALL hold stable.
REQ-028 Ordering SHALL be strict FIFO; no op is ever dropped or duplicated.
REQ-029 Sustained in_valid = out_ready = 1 SHALL give a throughput of one op per cycle.
REQ-030 In TWO, in_valid SHALL be ignored and the in_* lines SHALL NOT be sampled.

Reset
REQ-031 While rst is high at an edge, the state SHALL become EMPTY and out_valid SHALL become 0.
REQ-032 While rst is high, in_ready SHALL be 0; in_ready SHALL become 1 in the first cycle after rst deasserts.
REQ-033 On reset, out_result, out_rd and out_illegal SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard the OUT and SKID contents without presenting them.

Verification
REQ-035 SRL/SRA: rs1=80000000, rs2=0000001F. SRL -> out_result=00000001; SRA -> FFFFFFFF. rs1=A5A5A5A5, rs2=FFFFFF10, SRL -> 0000A5A5 (upper shift bits ignored).
REQ-036 Arithmetic and compare:
- ADD FFFFFFFF+1 -> 00000000.
- SUB 0-1 -> FFFFFFFF.
- SLT rs1=FFFFFFFF, rs2=1 -> 1.
- SLTU with the same operands -> 0.
REQ-037 Illegal and rd=0:
- funct3=101, funct7=0000001 -> out_illegal=1, out_result=0.
- ADD with in_rd=0, rs1=5, rs2=7 -> out_result=0.
REQ-038 Backpressure: hold out_ready=0 and offer 3 ops. Ops A and B are accepted and in_ready drops to 0. Then raise out_ready: A, B, C emerge in order, with out_* stable while stalled.
REQ-039 Streaming: in_valid = out_ready = 1 for 10 ops -> 10 results on consecutive cycles, each one cycle after its acceptance.
REQ-040 Reset with state TWO -> next cycle out_valid=0 and no stale result ever appears.

Source files
------------

// File: rtl/rtype_exec_stage.sv
// RV32I R-type execute stage: decodes funct3/funct7, computes the ALU result, buffers it in a 2-entry skid buffer.
// Latency: one cycle from the input transfer to out_valid.
// Backpressure: in_ready is registered and drops only when both OUT and SKID hold results, so out_ready never reaches it combinationally.
module rtype_exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            illegal;
    } res_t;

    occ_t            state;
    res_t            alu_dat;
    res_t            out_q;
    res_t            skid_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [4:0]      shamt;
    logic            accept;
    logic            drain;

    assign shamt = in_rs2[4:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case ({in_funct7, in_funct3})
            {7'h00, 3'b000}: alu_res = in_rs1 + in_rs2;
            {7'h20, 3'b000}: alu_res = in_rs1 - in_rs2;
            {7'h00, 3'b001}: alu_res = in_rs1 << shamt;
            {7'h00, 3'b010}: alu_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(in_rs2)};
            {7'h00, 3'b011}: alu_res = {{(XLEN-1){1'b0}}, in_rs1 < in_rs2};
            {7'h00, 3'b100}: alu_res = in_rs1 ^ in_rs2;
            {7'h00, 3'b101}: alu_res = in_rs1 >> shamt;
            {7'h20, 3'b101}: alu_res = $unsigned($signed(in_rs1) >>> shamt);
            {7'h00, 3'b110}: alu_res = in_rs1 | in_rs2;
            {7'h00, 3'b111}: alu_res = in_rs1 & in_rs2;
            default:         alu_ill = 1'b1;
        endcase
        // x0 is hardwired to zero, but an illegal encoding is still flagged
        alu_dat.result  = (in_rd == 5'd0) ? '0 : alu_res;
        alu_dat.rd      = in_rd;
        alu_dat.illegal = alu_ill;
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_q       <= alu_dat;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_q <= alu_dat;
                    end else if (accept) begin
                        skid_q     <= alu_dat;
                        in_ready_q <= 1'b0;
                        state      <= TWO;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Held low throughout reset; the register itself already reads 1 once reset lifts.
    assign in_ready    = in_ready_q && !rst;
    assign out_valid   = out_valid_q;
    assign out_result  = out_q.result;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rtype_exec_stage.sv
module tb_rtype_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    rtype_exec_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference: {illegal, rd, result} computed straight from the ISA rules.
    function automatic logic [37:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] rd);
        logic [31:0] r;
        logic        ill;
        logic [4:0]  sh;
        sh  = b[4:0];
        r   = 32'd0;
        ill = 1'b0;
        if (f7 == 7'h00) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = a << sh;
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
            r = a - b;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
            r = a >> sh;
            if (a[31]) r = r | ~(32'hFFFFFFFF >> sh);
        end else begin
            ill = 1'b1;
        end
        if (rd == 5'd0) r = 32'd0;
        return {ill, rd, r};
    endfunction

    function automatic logic [37:0] cur_in();
        return model(in_rs1, in_rs2, in_funct3, in_funct7, in_rd);
    endfunction

    function automatic logic [37:0] cur_out();
        return {out_illegal, out_rd, out_result};
    endfunction

    task automatic gen_op();
        int k;
        in_rs1 = $urandom;
        in_rs2 = $urandom;
        in_funct3 = 3'($urandom_range(0, 7));
        k = $urandom_range(0, 9);
        in_funct7 = (k < 6) ? 7'h00 : (k < 9) ? 7'h20 : 7'($urandom);
        in_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    endtask

    // Single op through an empty stage with out_ready high; returns what appeared on out_*.
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd,
                           output logic v, output logic [31:0] r, output logic [4:0] ro,
                           output logic il);
        in_rs1 = a; in_rs2 = b; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        v = out_valid; r = out_result; ro = out_rd; il = out_illegal;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", out_result); end
        total++; if (out_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", out_rd); end
        total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", out_illegal); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b want=0", out_valid); end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] er;
        logic        ei;
    } vec_t;

    task automatic test_directed();
        vec_t dv[11];
        logic v, il;
        logic [31:0] r;
        logic [4:0] ro;
        dv[0]  = '{32'h80000000, 32'h0000001F, 3'b101, 7'h00, 5'd1,  32'h00000001, 1'b0};
        dv[1]  = '{32'h80000000, 32'h0000001F, 3'b101, 7'h20, 5'd2,  32'hFFFFFFFF, 1'b0};
        dv[2]  = '{32'hA5A5A5A5, 32'hFFFFFF10, 3'b101, 7'h00, 5'd3,  32'h0000A5A5, 1'b0};
        dv[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b000, 7'h00, 5'd4,  32'h00000000, 1'b0};
        dv[4]  = '{32'h00000000, 32'h00000001, 3'b000, 7'h20, 5'd5,  32'hFFFFFFFF, 1'b0};
        dv[5]  = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 7'h00, 5'd6,  32'h00000001, 1'b0};
        dv[6]  = '{32'hFFFFFFFF, 32'h00000001, 3'b011, 7'h00, 5'd7,  32'h00000000, 1'b0};
        dv[7]  = '{32'h12345678, 32'h00000003, 3'b101, 7'h01, 5'd8,  32'h00000000, 1'b1};
        dv[8]  = '{32'h00000005, 32'h00000007, 3'b000, 7'h00, 5'd0,  32'h00000000, 1'b0};
        dv[9]  = '{32'hDEADBEEF, 32'hFFFFFFE0, 3'b001, 7'h00, 5'd31, 32'hDEADBEEF, 1'b0};
        dv[10] = '{32'h00000009, 32'h00000001, 3'b000, 7'h7F, 5'd0,  32'h00000000, 1'b1};
        foreach (dv[i]) begin
            send_op(dv[i].a, dv[i].b, dv[i].f3, dv[i].f7, dv[i].rd, v, r, ro, il);
            total++; if (v !== 1'b1) begin bad++; $display("FAIL directed_valid[%0d] got=%b want=1", i, v); end
            total++; if (r !== dv[i].er) begin bad++; $display("FAIL directed_result[%0d] got=%h want=%h", i, r, dv[i].er); end
            total++; if (il !== dv[i].ei) begin bad++; $display("FAIL directed_illegal[%0d] got=%b want=%b", i, il, dv[i].ei); end
            total++; if (ro !== dv[i].rd) begin bad++; $display("FAIL directed_rd[%0d] got=%h want=%h", i, ro, dv[i].rd); end
        end
    endtask

    task automatic test_backpressure();
        logic [37:0] ea, eb, ec;
        out_ready = 1'b0;
        gen_op(); ea = cur_in(); in_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || cur_out() !== ea) begin bad++; $display("FAIL bp_first got=%b/%h want=1/%h", out_valid, cur_out(), ea); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b want=1", in_ready); end
        gen_op(); eb = cur_in();
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_two got=%b want=0", in_ready); end
        gen_op(); ec = cur_in();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_stall[%0d] got=%b want=0", i, in_ready); end
            total++; if (out_valid !== 1'b1 || cur_out() !== ea) begin bad++; $display("FAIL bp_stable[%0d] got=%b/%h want=1/%h", i, out_valid, cur_out(), ea); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || cur_out() !== eb) begin bad++; $display("FAIL bp_second got=%b/%h want=1/%h", out_valid, cur_out(), eb); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || cur_out() !== ec) begin bad++; $display("FAIL bp_third got=%b/%h want=1/%h", out_valid, cur_out(), ec); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [37:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            gen_op(); e = cur_in(); in_valid = 1'b1;
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || cur_out() !== e) begin bad++; $display("FAIL stream[%0d] got=%b/%h want=1/%h", i, out_valid, cur_out(), e); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, in_ready); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        out_ready = 1'b0;
        gen_op(); in_valid = 1'b1;
        @(posedge clk); #1;
        gen_op();
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b want=0", in_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
        total++; if (cur_out() !== 38'd0) begin bad++; $display("FAIL rmid_data got=%h want=0", cur_out()); end
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%b want=0", seen); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_random();
        logic [37:0] q[$];
        int budget;
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            gen_op();
            total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rand_ready[%0d] got=%b occ=%0d", c, in_ready, q.size()); end
            total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rand_valid[%0d] got=%b occ=%0d", c, out_valid, q.size()); end
            if (q.size() > 0) begin
                total++; if (cur_out() !== q[0]) begin bad++; $display("FAIL rand_data[%0d] got=%h want=%h", c, cur_out(), q[0]); end
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(cur_in());
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            total++; if (out_valid !== 1'b1 || cur_out() !== q[0]) begin bad++; $display("FAIL rand_drain got=%b/%h want=1/%h", out_valid, cur_out(), q[0]); end
            void'(q.pop_front());
            @(posedge clk); #1;
            budget++;
        end
        total++; if (out_valid !== 1'b0 || q.size() != 0) begin bad++; $display("FAIL rand_final got=%b left=%0d want=0/0", out_valid, q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
